quantum_scheduler: RTL and testbench
====================================

Name: quantum_scheduler

Overview:
- Parametrised round-robin preemption controller for the LabSO processor, sitting between the control unit and the PC logic.
- Holds a ready bit and saved PC per process, counts retired instructions against a programmable quantum, and yields on I/O instructions or process end.
- Selects the next ready process and hands the control unit a resume PC through a req/ack handshake.

Parameters:
PC_W, 32, width of program counter
NPROC, 4, number of process slots (power of two, >=2)
PID_W, 2, log2(NPROC)
QUANTUM_W, 16, width of quantum register and slice counter
DEFAULT_QUANTUM, 10, quantum after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: begin scheduling from IDLE
proc_create  input  1  pulse: load slot create_pid with create_pc, mark ready
create_pid  input  PID_W  slot to load
create_pc  input  PC_W  entry PC of new process
instr_retire  input  1  one pulse per retired instruction
pc_next  input  PC_W  PC following the retiring instruction
io_instr  input  1  qualifies instr_retire: retiring instruction is I/O
proc_end  input  1  qualifies instr_retire: retiring instruction ends process
quantum_wr  input  1  pulse: write quantum_val
quantum_val  input  QUANTUM_W  new quantum (0 treated as 1)
switch_ack  input  1  control unit has loaded resume_pc
switch_req  output  1  context switch request, held until ack
switch_reason  output  2  0 START, 1 QUANTUM, 2 IO, 3 END
cur_pid  output  PID_W  running / incoming process
resume_pc  output  PC_W  PC to load for cur_pid
sched_active  output  1  high outside IDLE
all_done  output  1  one-cycle pulse when the last ready process ends
slice_count  output  QUANTUM_W  instructions retired in current slice

Behaviour:
- Reset (async, reset=0) values:
  - all outputs 0; all ready bits 0; saved PCs 0; quantum_reg = DEFAULT_QUANTUM; state IDLE.
- States: IDLE, RUN, SELECT, REQ.
- IDLE:
  - start with any ready slot: cur_pid = lowest ready pid; resume_pc = its PC; reason START; go to REQ.
  - start with no ready slot is ignored.
- REQ:
  - switch_req = 1; cur_pid, resume_pc and switch_reason are held stable until switch_ack.
  - On the ack cycle: switch_req = 0, slice_count = 0, active quantum latched from quantum_reg, go to RUN.
- RUN, on instr_retire (priority END > IO > QUANTUM):
  - proc_end: clear ready[cur_pid]; reason END; go to SELECT.
  - io_instr: saved_pc[cur_pid] = pc_next; reason IO; go to SELECT.
  - slice_count+1 == active quantum: saved_pc[cur_pid] = pc_next; reason QUANTUM; go to SELECT.
  - otherwise: slice_count += 1.
- SELECT (exactly 1 cycle):
  - Search pids cur_pid+1, cur_pid+2, ... wrapping modulo NPROC; cur_pid is checked last.
  - None ready: all_done pulses 1 cycle; go to IDLE; cur_pid unchanged.
  - Found pid == cur_pid (sole survivor, IO/QUANTUM): no request; slice_count = 0; quantum re-latched; back to RUN.
  - Found other pid: cur_pid = pid; resume_pc = saved_pc[pid]; go to REQ.
- instr_retire is ignored in IDLE, SELECT and REQ.
- Arithmetic: pid wrap is modulo NPROC; slice_count never exceeds active quantum; no overflow is possible.
- quantum_wr is accepted in any state and updates quantum_reg next cycle. It takes effect only at the next latch (REQ ack or sole-survivor restart), never mid-slice.
- proc_create is accepted in any state:
  - ignored if create_pid == cur_pid while not IDLE.
  - otherwise overwrites the slot's PC and sets ready the next cycle.
  - If it coincides with proc_end on a different pid, both take effect.
  - A slot created during SELECT is visible to that SELECT only from the following cycle.
- switch_ack outside REQ is ignored.
- Reset mid-REQ drops switch_req immediately (asynchronous).

Test Plan:
- Create pid0 PC 0x100, pid1 PC 0x200, start -> REQ cur_pid=0 resume_pc=0x100 reason 0; after ack, 10 retires with pc_next 0x101..0x10A -> REQ cur_pid=1 resume_pc=0x200 reason 1; saved_pc[0]=0x10A.
- pid1 running, retire with io_instr at pc_next 0x205 after 3 retires -> REQ cur_pid=0 resume_pc=0x10A reason 2; slice_count reset after ack.
- Only pid2 ready, quantum 4 -> after 4 retires no switch_req; slice_count returns to 0; RUN continues.
- proc_end and io_instr on the same retire, other slots empty -> reason END, all_done pulses 1 cycle, sched_active=0.
- quantum_wr 3 during a slice with quantum 10 -> current slice still switches at 10; next slice switches at 3. quantum_val 0 -> switch after 1 retire.
- Reset asserted while switch_req=1 and no ack -> switch_req=0 immediately; ready bits cleared; start afterwards is ignored.

Source files
------------

// File: rtl/quantum_scheduler_if.sv
// Bus between the control unit / PC logic and the quantum scheduler.
//
// Handshake: the scheduler raises switch_req and holds cur_pid, resume_pc
// and switch_reason stable until the control unit asserts switch_ack. The
// transfer completes on the rising clock edge where switch_req and
// switch_ack are both high. switch_ack outside a pending request is ignored.
//
// master : control-unit side (drives commands, retire info and switch_ack)
// slave  : scheduler side (drives switch request, pid/pc, status, debug state)
interface quantum_scheduler_if #(
  parameter int PC_W      = 32,
  parameter int PID_W     = 2,
  parameter int QUANTUM_W = 16
);
  logic                 start;
  logic                 proc_create;
  logic [PID_W-1:0]     create_pid;
  logic [PC_W-1:0]      create_pc;
  logic                 instr_retire;
  logic [PC_W-1:0]      pc_next;
  logic                 io_instr;
  logic                 proc_end;
  logic                 quantum_wr;
  logic [QUANTUM_W-1:0] quantum_val;
  logic                 switch_ack;

  logic                 switch_req;
  logic [1:0]           switch_reason;
  logic [PID_W-1:0]     cur_pid;
  logic [PC_W-1:0]      resume_pc;
  logic                 sched_active;
  logic                 all_done;
  logic [QUANTUM_W-1:0] slice_count;
  logic [1:0]           dbg_state;

  modport master (
    output start, proc_create, create_pid, create_pc, instr_retire, pc_next,
           io_instr, proc_end, quantum_wr, quantum_val, switch_ack,
    input  switch_req, switch_reason, cur_pid, resume_pc, sched_active,
           all_done, slice_count, dbg_state
  );

  modport slave (
    input  start, proc_create, create_pid, create_pc, instr_retire, pc_next,
           io_instr, proc_end, quantum_wr, quantum_val, switch_ack,
    output switch_req, switch_reason, cur_pid, resume_pc, sched_active,
           all_done, slice_count, dbg_state
  );
endinterface

// File: rtl/quantum_scheduler.sv
// Round-robin preemption controller. Keeps a ready bit and saved PC per
// process slot, counts retired instructions against a programmable quantum
// and yields on I/O, process end or quantum expiry, then hands the next
// ready process to the control unit through the switch_req/switch_ack bus.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - quantum_scheduler_if.slave (commands in, switch request out,
//           status outputs, dbg_state = current FSM state)
module quantum_scheduler #(
  parameter int PC_W            = 32,
  parameter int NPROC           = 4,
  parameter int PID_W           = 2,
  parameter int QUANTUM_W       = 16,
  parameter int DEFAULT_QUANTUM = 10
) (
  input logic                 clock,
  input logic                 reset,
  quantum_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SELECT, S_REQ} state_e;

  localparam logic [1:0] R_START   = 2'd0;
  localparam logic [1:0] R_QUANTUM = 2'd1;
  localparam logic [1:0] R_IO      = 2'd2;
  localparam logic [1:0] R_END     = 2'd3;

  state_e               state_q, state_d;
  logic [NPROC-1:0]     ready_q, ready_d;
  logic [PC_W-1:0]      saved_pc_q [NPROC];
  logic [PC_W-1:0]      saved_pc_d [NPROC];
  logic [PID_W-1:0]     cur_pid_q, cur_pid_d;
  logic [PC_W-1:0]      resume_pc_q, resume_pc_d;
  logic [1:0]           reason_q, reason_d;
  logic [QUANTUM_W-1:0] slice_q, slice_d;
  logic [QUANTUM_W-1:0] active_q, active_d;
  logic [QUANTUM_W-1:0] quantum_q, quantum_d;
  logic                 all_done_q, all_done_d;

  logic [PID_W-1:0]     low_pid;
  logic [PID_W-1:0]     rr_pid;
  logic                 rr_found;
  logic [PID_W-1:0]     cand;
  logic [QUANTUM_W-1:0] latch_val;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    saved_pc_d  = saved_pc_q;
    cur_pid_d   = cur_pid_q;
    resume_pc_d = resume_pc_q;
    reason_d    = reason_q;
    slice_d     = slice_q;
    active_d    = active_q;
    quantum_d   = quantum_q;
    all_done_d  = 1'b0;
    low_pid     = '0;
    rr_pid      = cur_pid_q;
    rr_found    = 1'b0;
    cand        = '0;

    // A programmed quantum of zero behaves as a quantum of one.
    latch_val = (quantum_q == '0) ? QUANTUM_W'(1) : quantum_q;

    // Lowest ready slot: scan downwards so the smallest index wins.
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (ready_q[i]) low_pid = PID_W'(i);
    end

    // Round-robin search from cur_pid+1; k = NPROC wraps to cur_pid itself,
    // which is therefore the last candidate. Scanning k downwards lets the
    // nearest successor win.
    for (int k = NPROC; k >= 1; k--) begin
      cand = cur_pid_q + PID_W'(k);
      if (ready_q[cand]) begin
        rr_found = 1'b1;
        rr_pid   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && (ready_q != '0)) begin
          cur_pid_d   = low_pid;
          resume_pc_d = saved_pc_q[low_pid];
          reason_d    = R_START;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.switch_ack) begin
          slice_d  = '0;
          active_d = latch_val;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.instr_retire) begin
          if (bus.proc_end) begin
            ready_d[cur_pid_q] = 1'b0;
            reason_d           = R_END;
            state_d            = S_SELECT;
          end else if (bus.io_instr) begin
            saved_pc_d[cur_pid_q] = bus.pc_next;
            reason_d              = R_IO;
            state_d               = S_SELECT;
          end else if (slice_q + QUANTUM_W'(1) == active_q) begin
            saved_pc_d[cur_pid_q] = bus.pc_next;
            reason_d              = R_QUANTUM;
            state_d               = S_SELECT;
          end else begin
            slice_d = slice_q + QUANTUM_W'(1);
          end
        end
      end
      S_SELECT: begin
        if (!rr_found) begin
          all_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (rr_pid == cur_pid_q) begin
          // Sole survivor keeps running without a context switch.
          slice_d  = '0;
          active_d = latch_val;
          state_d  = S_RUN;
        end else begin
          cur_pid_d   = rr_pid;
          resume_pc_d = saved_pc_q[rr_pid];
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The running/incoming slot cannot be overwritten while scheduling.
    if (bus.proc_create && !((state_q != S_IDLE) && (bus.create_pid == cur_pid_q))) begin
      saved_pc_d[bus.create_pid] = bus.create_pc;
      ready_d[bus.create_pid]    = 1'b1;
    end

    if (bus.quantum_wr) quantum_d = bus.quantum_val;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ready_q     <= '0;
      for (int i = 0; i < NPROC; i++) saved_pc_q[i] <= '0;
      cur_pid_q   <= '0;
      resume_pc_q <= '0;
      reason_q    <= '0;
      slice_q     <= '0;
      active_q    <= '0;
      quantum_q   <= QUANTUM_W'(DEFAULT_QUANTUM);
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      saved_pc_q  <= saved_pc_d;
      cur_pid_q   <= cur_pid_d;
      resume_pc_q <= resume_pc_d;
      reason_q    <= reason_d;
      slice_q     <= slice_d;
      active_q    <= active_d;
      quantum_q   <= quantum_d;
      all_done_q  <= all_done_d;
    end
  end

  assign bus.switch_req    = (state_q == S_REQ);
  assign bus.switch_reason = reason_q;
  assign bus.cur_pid       = cur_pid_q;
  assign bus.resume_pc     = resume_pc_q;
  assign bus.sched_active  = (state_q != S_IDLE);
  assign bus.all_done      = all_done_q;
  assign bus.slice_count   = slice_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_quantum_scheduler.sv
module tb_quantum_scheduler;
  localparam int W = 36;  // {reason[1:0], pid[1:0], pc[31:0]}

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  quantum_scheduler_if #(.PC_W(32), .PID_W(2), .QUANTUM_W(16)) bus ();

  quantum_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_switch(input string name);
    logic [W-1:0] e;
    check({name, "_req"}, 64'(bus.switch_req), 64'd1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_xfer"}, 64'({bus.switch_reason, bus.cur_pid, bus.resume_pc}), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.proc_create = 0; bus.create_pid = '0; bus.create_pc = '0;
    bus.instr_retire = 0; bus.pc_next = '0; bus.io_instr = 0; bus.proc_end = 0;
    bus.quantum_wr = 0; bus.quantum_val = '0; bus.switch_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic create(input logic [1:0] pid, input logic [31:0] pc);
    bus.proc_create = 1; bus.create_pid = pid; bus.create_pc = pc;
    tick();
    bus.proc_create = 0;
  endtask

  task automatic start_sched();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic set_quantum(input logic [15:0] q);
    bus.quantum_wr = 1; bus.quantum_val = q;
    tick();
    bus.quantum_wr = 0;
  endtask

  task automatic ack();
    bus.switch_ack = 1;
    tick();
    bus.switch_ack = 0;
  endtask

  task automatic retire(input logic io, input logic pe, input logic [31:0] pc);
    bus.instr_retire = 1; bus.io_instr = io; bus.proc_end = pe; bus.pc_next = pc;
    tick();
    bus.instr_retire = 0; bus.io_instr = 0; bus.proc_end = 0;
  endtask

  // ---------------- reference model ----------------
  logic        m_ready [4];
  logic [31:0] m_pc    [4];
  int          m_cur;
  int          m_qreg;
  int          m_active;
  int          m_slice;

  function automatic void m_latch();
    m_active = (m_qreg == 0) ? 1 : m_qreg;
    m_slice  = 0;
  endfunction

  function automatic int m_next();
    for (int k = 1; k <= 4; k++) begin
      if (m_ready[(m_cur + k) % 4]) return (m_cur + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0] mask;
    logic       exp_req;
    logic [1:0] exp_pid;
    logic       exp_next_req;
    logic [1:0] exp_next;
  } vec_t;
  vec_t vecs [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    clear_inputs();

    vecs[0] = '{4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[1] = '{4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
    vecs[2] = '{4'b0110, 1'b1, 2'd1, 1'b1, 2'd2};
    vecs[3] = '{4'b1000, 1'b1, 2'd3, 1'b0, 2'd3};
    vecs[4] = '{4'b1001, 1'b1, 2'd0, 1'b1, 2'd3};
    vecs[5] = '{4'b1011, 1'b1, 2'd0, 1'b1, 2'd1};
    vecs[6] = '{4'b1010, 1'b1, 2'd1, 1'b1, 2'd3};
    vecs[7] = '{4'b1111, 1'b1, 2'd0, 1'b1, 2'd1};

    // ---- reset values ----
    do_reset();
    check("rst_req",    64'(bus.switch_req),    64'd0);
    check("rst_reason", 64'(bus.switch_reason), 64'd0);
    check("rst_pid",    64'(bus.cur_pid),       64'd0);
    check("rst_pc",     64'(bus.resume_pc),     64'd0);
    check("rst_active", 64'(bus.sched_active),  64'd0);
    check("rst_done",   64'(bus.all_done),      64'd0);
    check("rst_slice",  64'(bus.slice_count),   64'd0);

    // ---- table: start selection and first round-robin successor ----
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int p = 0; p < 4; p++)
        if (vecs[v].mask[p]) create(2'(p), 32'h100 * (p + 1));
      start_sched();
      check($sformatf("tbl%0d_req", v), 64'(bus.switch_req), 64'(vecs[v].exp_req));
      if (vecs[v].exp_req) begin
        check($sformatf("tbl%0d_pid", v), 64'(bus.cur_pid), 64'(vecs[v].exp_pid));
        check($sformatf("tbl%0d_pc", v), 64'(bus.resume_pc), 64'h100 * (vecs[v].exp_pid + 1));
        ack();
        retire(1'b1, 1'b0, 32'hABC);
        tick();
        check($sformatf("tbl%0d_next_req", v), 64'(bus.switch_req), 64'(vecs[v].exp_next_req));
        if (vecs[v].exp_next_req) begin
          check($sformatf("tbl%0d_next_pid", v), 64'(bus.cur_pid), 64'(vecs[v].exp_next));
          check($sformatf("tbl%0d_next_pc", v), 64'(bus.resume_pc), 64'h100 * (vecs[v].exp_next + 1));
        end else begin
          check($sformatf("tbl%0d_sole_slice", v), 64'(bus.slice_count), 64'd0);
          check($sformatf("tbl%0d_sole_act", v), 64'(bus.sched_active), 64'd1);
        end
      end
    end

    // ---- quantum switch, I/O yield, end and all_done ----
    do_reset();
    create(2'd0, 32'h100);
    create(2'd1, 32'h200);
    start_sched();
    check("s1_start", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd0, 2'd0, 32'h100}));
    ack();
    check("s1_ack_req", 64'(bus.switch_req), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      retire(1'b0, 1'b0, 32'h100 + i);
      if (i < 10) check("s1_slice", 64'(bus.slice_count), 64'(i));
    end
    tick();
    check("s1_quantum", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd1, 2'd1, 32'h200}));
    ack();
    for (int i = 1; i <= 3; i++) retire(1'b0, 1'b0, 32'h200 + i);
    retire(1'b1, 1'b0, 32'h205);
    tick();
    check("s1_io", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd2, 2'd0, 32'h10A}));
    ack();
    check("s1_io_slice", 64'(bus.slice_count), 64'd0);
    retire(1'b0, 1'b1, 32'h10B);
    tick();
    check("s1_end", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd3, 2'd1, 32'h205}));
    ack();
    retire(1'b1, 1'b1, 32'h206);
    tick();
    check("s1_done",        64'(bus.all_done),      64'd1);
    check("s1_done_active", 64'(bus.sched_active),  64'd0);
    check("s1_done_reason", 64'(bus.switch_reason), 64'd3);
    check("s1_done_req",    64'(bus.switch_req),    64'd0);
    tick();
    check("s1_done_pulse",  64'(bus.all_done),      64'd0);

    // ---- sole survivor restarts without a request ----
    do_reset();
    set_quantum(16'd4);
    create(2'd2, 32'h300);
    start_sched();
    check("s2_start", 64'({bus.cur_pid, bus.resume_pc}), 64'({2'd2, 32'h300}));
    ack();
    for (int i = 1; i <= 3; i++) begin
      retire(1'b0, 1'b0, 32'h300 + i);
      check("s2_slice", 64'(bus.slice_count), 64'(i));
    end
    retire(1'b0, 1'b0, 32'h304);
    tick();
    check("s2_noreq",  64'(bus.switch_req),   64'd0);
    check("s2_slice0", 64'(bus.slice_count),  64'd0);
    check("s2_run",    64'(bus.sched_active), 64'd1);
    retire(1'b0, 1'b0, 32'h305);
    check("s2_slice1", 64'(bus.slice_count),  64'd1);

    // ---- quantum write takes effect at the next latch; zero acts as one ----
    do_reset();
    create(2'd0, 32'h100);
    create(2'd1, 32'h200);
    start_sched();
    ack();
    retire(1'b0, 1'b0, 32'h101);
    retire(1'b0, 1'b0, 32'h102);
    set_quantum(16'd3);
    for (int i = 3; i <= 10; i++) begin
      retire(1'b0, 1'b0, 32'h100 + i);
      if (i < 10) check("s3_noswitch", 64'(bus.slice_count), 64'(i));
    end
    tick();
    check("s3_old_q", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid}), 64'({1'b1, 2'd1, 2'd1}));
    ack();
    set_quantum(16'd0);
    retire(1'b0, 1'b0, 32'h201);
    retire(1'b0, 1'b0, 32'h202);
    check("s3_slice2", 64'(bus.slice_count), 64'd2);
    retire(1'b0, 1'b0, 32'h203);
    tick();
    check("s3_new_q", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd1, 2'd0, 32'h10A}));
    ack();
    retire(1'b0, 1'b0, 32'h10B);
    tick();
    check("s3_zero_q", 64'({bus.switch_req, bus.switch_reason, bus.cur_pid, bus.resume_pc}),
          64'({1'b1, 2'd1, 2'd1, 32'h203}));

    // ---- create on running pid ignored; create alongside proc_end ----
    do_reset();
    create(2'd0, 32'h100);
    create(2'd1, 32'h200);
    start_sched();
    ack();
    create(2'd0, 32'h999);
    retire(1'b1, 1'b0, 32'h111);
    tick();
    check("s4_io1", 64'({bus.cur_pid, bus.resume_pc}), 64'({2'd1, 32'h200}));
    ack();
    retire(1'b1, 1'b0, 32'h222);
    tick();
    check("s4_ignored", 64'({bus.cur_pid, bus.resume_pc}), 64'({2'd0, 32'h111}));
    ack();
    bus.proc_create = 1; bus.create_pid = 2'd2; bus.create_pc = 32'h300;
    retire(1'b0, 1'b1, 32'h112);
    bus.proc_create = 0;
    tick();
    check("s4_end_sel", 64'({bus.switch_reason, bus.cur_pid, bus.resume_pc}), 64'({2'd3, 2'd1, 32'h222}));
    ack();
    retire(1'b0, 1'b1, 32'h223);
    tick();
    check("s4_created", 64'({bus.switch_reason, bus.cur_pid, bus.resume_pc}), 64'({2'd3, 2'd2, 32'h300}));
    ack();
    retire(1'b0, 1'b1, 32'h301);
    tick();
    check("s4_done", 64'({bus.all_done, bus.sched_active}), 64'({1'b1, 1'b0}));

    // ---- asynchronous reset while a request is pending ----
    do_reset();
    create(2'd0, 32'h100);
    start_sched();
    check("s5_req", 64'(bus.switch_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_req",    64'(bus.switch_req),   64'd0);
    check("s5_async_active", 64'(bus.sched_active), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    start_sched();
    tick();
    check("s5_start_ignored", 64'({bus.switch_req, bus.sched_active}), 64'd0);

    // ---- randomized rounds against the reference model ----
    for (int r = 0; r < 20; r++) begin
      logic [3:0] mask;
      int steps;
      bit round_done;
      do_reset();
      m_qreg = $urandom_range(0, 5);
      set_quantum(16'(m_qreg));
      mask = 4'($urandom_range(1, 15));
      m_cur = -1;
      for (int p = 0; p < 4; p++) begin
        m_ready[p] = mask[p];
        m_pc[p]    = '0;
        if (mask[p]) begin
          m_pc[p] = $urandom;
          create(2'(p), m_pc[p]);
          if (m_cur < 0) m_cur = p;
        end
      end
      start_sched();
      exp_q.push_back({2'd0, 2'(m_cur), m_pc[m_cur]});
      check_switch("rnd_start");
      round_done = 0;
      steps = 0;
      // ack after a random wait; the request must stay stable meanwhile
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        tick();
        check("rnd_hold", 64'({bus.switch_req, bus.cur_pid}), 64'({1'b1, 2'(m_cur)}));
      end
      ack();
      m_latch();
      while (!round_done && steps < 80) begin
        logic io, pe;
        logic [31:0] pc;
        int reason;
        int nxt;
        bit yield;
        if ($urandom_range(0, 1) == 1) tick();
        io = ($urandom_range(0, 4) == 0);
        pe = ($urandom_range(0, 5) == 0);
        pc = $urandom;
        retire(io, pe, pc);
        steps++;
        yield = 1;
        reason = 0;
        if (pe) begin
          m_ready[m_cur] = 0; reason = 3;
        end else if (io) begin
          m_pc[m_cur] = pc; reason = 2;
        end else if (m_slice + 1 == m_active) begin
          m_pc[m_cur] = pc; reason = 1;
        end else begin
          m_slice++;
          yield = 0;
          check("rnd_slice", 64'(bus.slice_count), 64'(m_slice));
        end
        if (yield) begin
          tick();
          nxt = m_next();
          if (nxt < 0) begin
            check("rnd_done", 64'({bus.all_done, bus.sched_active, bus.switch_reason}),
                  64'({1'b1, 1'b0, 2'(reason)}));
            round_done = 1;
          end else if (nxt == m_cur) begin
            check("rnd_sole", 64'({bus.switch_req, bus.sched_active, bus.slice_count}),
                  64'({1'b0, 1'b1, 16'd0}));
            m_latch();
          end else begin
            m_cur = nxt;
            exp_q.push_back({2'(reason), 2'(m_cur), m_pc[m_cur]});
            check_switch("rnd_switch");
            for (int d = $urandom_range(0, 2); d > 0; d--) begin
              tick();
              check("rnd_hold", 64'({bus.switch_req, bus.cur_pid}), 64'({1'b1, 2'(m_cur)}));
            end
            ack();
            m_latch();
            check("rnd_ack", 64'({bus.switch_req, bus.slice_count}), 64'd0);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
